// File: rtl/rt_uart_tx.sv
// rt_uart_tx: UART transmitter with a byte FIFO. It sends 8N1 frames, LSB first, with a bit
// period set by div_i (in clk_i cycles).
// Optional feature: define RT_UART_TX_PARITY_EN to add the parity_odd_i port and a parity bit
// after the data bits, which gives 11-bit frames.
module rt_uart_tx #(
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned DivW      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [DivW-1:0]                div_i,
`ifdef RT_UART_TX_PARITY_EN
  input  logic                           parity_odd_i,
`endif
  input  logic [7:0]                     data_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic                           tx_o,
  output logic                           busy_o,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_cnt_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = $clog2(FifoDepth);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [DivW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
`ifdef RT_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic            push, pop, fifo_nempty, bit_end;
  logic [DivW-1:0] div_lat;
  logic [7:0]      head;

  assign ready_o     = (count_q != CntW'(FifoDepth));
  assign fifo_nempty = (count_q != '0);
  assign push        = valid_i & ready_o;
  assign busy_o      = (state_q != StIdle) | fifo_nempty;
  assign fifo_cnt_o  = count_q;
  assign tx_o        = tx_q;
  assign bit_end     = (cnt_q == '0);
  // A divisor of 0 would stall the down-counter, so treat it as 1.
  assign div_lat     = (div_i == '0) ? DivW'(1) : div_i;
  assign head        = mem_q[rd_ptr_q];

  // Next-state logic for the frame FSM, the bit timer and the shifter.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
`ifdef RT_UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          state_d = StStart;
          div_d   = div_lat;
          cnt_d   = div_lat - DivW'(1);
          shift_d = head;
`ifdef RT_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          cnt_d     = div_q - DivW'(1);
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q - DivW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = div_q - DivW'(1);
          if (bit_idx_q == 3'd7) begin
`ifdef RT_UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q ^ parity_odd_i;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - DivW'(1);
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = div_q - DivW'(1);
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - DivW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          if (fifo_nempty) begin
            // Back-to-back frame: no idle cycle between the stop bit and the next start bit.
            pop     = 1'b1;
            state_d = StStart;
            div_d   = div_lat;
            cnt_d   = div_lat - DivW'(1);
            shift_d = head;
`ifdef RT_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DivW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      div_q     <= DivW'(1);
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef RT_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef RT_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // FIFO occupancy: a simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; the pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage. The storage has no reset, because the count and pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_rt_uart_tx.sv
// Directed testbench for rt_uart_tx. It checks frame timing, FIFO backpressure, mid-frame reset
// and the divisor-0 case. With RT_UART_TX_PARITY_EN defined it also checks the parity bit.
module tb_rt_uart_tx;

  localparam int unsigned FifoDepth = 8;
  localparam int unsigned DivW      = 16;
`ifdef RT_UART_TX_PARITY_EN
  localparam int Flen = 11;
`else
  localparam int Flen = 10;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DivW-1:0] div;
  logic [7:0]      data;
  logic            valid;
  logic            ready, tx, busy;
  logic [3:0]      fifo_cnt;
`ifdef RT_UART_TX_PARITY_EN
  logic            parity_odd;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rt_uart_tx #(
    .FifoDepth(FifoDepth),
    .DivW     (DivW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .div_i       (div),
`ifdef RT_UART_TX_PARITY_EN
    .parity_odd_i(parity_odd),
`endif
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .tx_o        (tx),
    .busy_o      (busy),
    .fifo_cnt_o  (fifo_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level at frame bit position idx (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef RT_UART_TX_PARITY_EN
    if (idx == 9) return (^b) ^ parity_odd;
`endif
    return 1'b1;
  endfunction

  // Push one byte into an idle, empty transmitter and check the whole frame cycle by cycle.
  task automatic send_check(input string tag, input logic [7:0] b, input logic [DivW-1:0] d,
                            input int div_eff);
    div   = d;
    data  = b;
    valid = 1'b1;
    chk({tag, " ready before push"}, 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    chk({tag, " cnt after push"}, 32'(fifo_cnt), 32'd1);
    chk({tag, " tx idle after push"}, 32'(tx), 32'd1);
    chk({tag, " busy after push"}, 32'(busy), 32'd1);
    tick();
    chk({tag, " cnt after pop"}, 32'(fifo_cnt), 32'd0);
    for (int s = 0; s < Flen * div_eff; s++) begin
      chk($sformatf("%s tx cyc %0d", tag, s), 32'(tx), 32'(exp_bit(b, s / div_eff)));
      if (s == Flen * div_eff - 1) chk({tag, " busy last stop cyc"}, 32'(busy), 32'd1);
      tick();
    end
    chk({tag, " busy after frame"}, 32'(busy), 32'd0);
    chk({tag, " tx idle after frame"}, 32'(tx), 32'd1);
  endtask

  logic [7:0] bytes [10];

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    div   = DivW'(4);
`ifdef RT_UART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) tick();
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cnt", 32'(fifo_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // div 4, 0x55
    send_check("t1", 8'h55, DivW'(4), 4);

    // div 0 behaves as 1, 0xA3
    send_check("t3", 8'hA3, DivW'(0), 1);

    // div 16: push 10 bytes back to back; the tenth is refused
    div = DivW'(16);
    for (int i = 0; i < 10; i++) bytes[i] = 8'(8'h30 + i * 7);
    for (int i = 0; i < 10; i++) begin
      data  = bytes[i];
      valid = 1'b1;
      chk($sformatf("t2 ready push %0d", i), 32'(ready), 32'(i < 9));
      tick();
    end
    valid = 1'b0;
    chk("t2 cnt full", 32'(fifo_cnt), 32'd8);
    // The first start edge was one edge after the first push, so this sample is 8 cycles in.
    for (int s = 8; s < 9 * Flen * 16; s++) begin
      chk($sformatf("t2 tx cyc %0d", s), 32'(tx),
          32'(exp_bit(bytes[s / (Flen * 16)], (s % (Flen * 16)) / 16)));
      if (s == Flen * 16 - 1) chk("t2 ready before frame1 end", 32'(ready), 32'd0);
      if (s == Flen * 16) begin
        chk("t2 ready at frame1 end", 32'(ready), 32'd1);
        chk("t2 cnt at frame1 end", 32'(fifo_cnt), 32'd7);
      end
      tick();
    end
    chk("t2 busy after 9 frames", 32'(busy), 32'd0);
    chk("t2 cnt after 9 frames", 32'(fifo_cnt), 32'd0);

    // div 8: reset during data bit 3 with a second byte still queued
    div   = DivW'(8);
    data  = 8'h3C;
    valid = 1'b1;
    tick();
    data  = 8'h99;
    tick();
    valid = 1'b0;
    repeat (34) tick();
    chk("t4 tx in bit3", 32'(tx), 32'(exp_bit(8'h3C, 4)));
    chk("t4 busy in frame", 32'(busy), 32'd1);
    chk("t4 cnt queued", 32'(fifo_cnt), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t4 tx after reset", 32'(tx), 32'd1);
    chk("t4 cnt after reset", 32'(fifo_cnt), 32'd0);
    chk("t4 busy after reset", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t4 tx idle after release", 32'(tx), 32'd1);
    chk("t4 busy idle after release", 32'(busy), 32'd0);
    send_check("t4 post", 8'h81, DivW'(8), 8);

`ifdef RT_UART_TX_PARITY_EN
    parity_odd = 1'b0;
    send_check("t5 even", 8'h07, DivW'(4), 4);
    parity_odd = 1'b1;
    send_check("t5 odd", 8'h07, DivW'(4), 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
